// File: rtl/bsg_wormhole_router_adapter_in_mc.sv
// Multi-channel packet-to-flit serializer for the wormhole injection port.
// Round-robin picks one client packet and sends len+1 flits LSB-first.
module bsg_wormhole_router_adapter_in_mc #(
  parameter int flit_width_p        = 8,
  parameter int max_payload_width_p = 17,
  parameter int cord_width_p        = 4,
  parameter int len_width_p         = 2,
  parameter int num_in_p            = 2,
  localparam int pkt_w  = max_payload_width_p + len_width_p + cord_width_p,
  localparam int chan_w = (num_in_p > 1) ? $clog2(num_in_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [num_in_p*pkt_w-1:0] packet_i,
  input  logic [num_in_p-1:0]       packet_v_i,
  output logic [num_in_p-1:0]       packet_ready_and_o,
  output logic [flit_width_p-1:0]   link_data_o,
  output logic                      link_v_o,
  input  logic                      link_ready_and_i,
  output logic [chan_w-1:0]         chan_o,
  output logic                      error_o
);

  localparam int max_flits = (pkt_w + flit_width_p - 1) / flit_width_p;
  localparam int cnt_w     = (max_flits > 1) ? $clog2(max_flits) : 1;
  localparam int pad_w     = max_flits * flit_width_p;

  typedef enum logic {IDLE, SEND} state_e;

  state_e                  state_r, state_n;
  logic [cnt_w-1:0]        cnt_r, last_r;
  logic [pkt_w-1:0]        packet_r;
  logic [chan_w-1:0]       chan_r, rr_r;
  logic                    error_r;

  logic [2*num_in_p-1:0]   rot;
  logic [chan_w-1:0]       off, grant, grant_inc;
  logic [chan_w:0]         sum;
  logic                    any_v, arb_live, accept, link_fire, pkt_done;
  logic [pkt_w-1:0]        sel_pkt;
  logic [len_width_p-1:0]  sel_len;
  logic                    oversize;
  logic [cnt_w-1:0]        sel_last;
  logic [pad_w-1:0]        padded;

  // Rotate valids so bit 0 is the rr pointer; the lowest set bit wins.
  always_comb begin
    any_v = |packet_v_i;
    rot   = {packet_v_i, packet_v_i} >> rr_r;
    off   = '0;
    for (int unsigned i = num_in_p; i > 0; i--) begin
      if (rot[i-1]) off = chan_w'(i-1);
    end
    sum = {1'b0, rr_r} + {1'b0, off};
    if (sum >= (chan_w+1)'(num_in_p)) sum = sum - (chan_w+1)'(num_in_p);
    grant     = sum[chan_w-1:0];
    grant_inc = (grant == chan_w'(num_in_p-1)) ? '0 : grant + chan_w'(1);
  end

  always_comb begin
    sel_pkt = '0;
    for (int unsigned i = 0; i < num_in_p; i++) begin
      if (grant == chan_w'(i)) sel_pkt = packet_i[i*pkt_w +: pkt_w];
    end
    sel_len  = sel_pkt[cord_width_p +: len_width_p];
    oversize = 32'(sel_len) >= 32'(max_flits);
    sel_last = oversize ? cnt_w'(max_flits-1) : cnt_w'(sel_len);
  end

  assign link_fire = (state_r == SEND) && link_ready_and_i;
  assign pkt_done  = link_fire && (cnt_r == last_r);
  // The arbiter is also live on the last-flit handshake for zero-bubble reload.
  assign arb_live  = (state_r == IDLE) || pkt_done;

  always_comb begin
    packet_ready_and_o = '0;
    for (int unsigned i = 0; i < num_in_p; i++) begin
      packet_ready_and_o[i] = reset_n_i && arb_live && any_v && (grant == chan_w'(i));
    end
  end

  assign accept = |(packet_v_i & packet_ready_and_o);

  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: if (accept) state_n = SEND;
      SEND: if (pkt_done && !accept) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      last_r   <= '0;
      packet_r <= '0;
      chan_r   <= '0;
      rr_r     <= '0;
      error_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      if (accept) begin
        packet_r <= sel_pkt;
        chan_r   <= grant;
        last_r   <= sel_last;
        cnt_r    <= '0;
        rr_r     <= grant_inc;
        if (oversize) error_r <= 1'b1;
      end else if (link_fire && !pkt_done) begin
        cnt_r <= cnt_r + cnt_w'(1);
      end
    end
  end

  always_comb begin
    padded              = '0;
    padded[pkt_w-1:0]   = packet_r;
    link_data_o         = '0;
    for (int unsigned f = 0; f < max_flits; f++) begin
      if (cnt_r == cnt_w'(f)) link_data_o = padded[f*flit_width_p +: flit_width_p];
    end
  end

  assign link_v_o = (state_r == SEND);
  assign chan_o   = chan_r;
  assign error_o  = error_r;

endmodule

// File: tb/tb_bsg_wormhole_router_adapter_in_mc.sv
// Directed bench for bsg_wormhole_router_adapter_in_mc (default parameters).
// Observed vector per cycle: {link_v, data, chan, ready[1:0], error}.
module tb_bsg_wormhole_router_adapter_in_mc;

  localparam int N   = 2;
  localparam int PKW = 23;

  logic           clk = 1'b0;
  logic           reset_n_i;
  logic [N*PKW-1:0] packet_i;
  logic [N-1:0]   packet_v_i;
  logic [N-1:0]   packet_ready_and_o;
  logic [7:0]     link_data_o;
  logic           link_v_o;
  logic           link_ready_and_i;
  logic           chan_o;
  logic           error_o;

  int vec_cnt = 0;
  int mis_cnt = 0;

  bsg_wormhole_router_adapter_in_mc #(
    .flit_width_p(8), .max_payload_width_p(17), .cord_width_p(4),
    .len_width_p(2), .num_in_p(N)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .packet_i(packet_i), .packet_v_i(packet_v_i),
    .packet_ready_and_o(packet_ready_and_o),
    .link_data_o(link_data_o), .link_v_o(link_v_o),
    .link_ready_and_i(link_ready_and_i),
    .chan_o(chan_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [12:0] ex(input logic v, input logic [7:0] d, input logic ch,
                                     input logic [1:0] rdy, input logic err);
    return v ? {v, d, ch, rdy, err} : {1'b0, 8'h00, 1'b0, rdy, err};
  endfunction

  function automatic logic [12:0] observe();
    logic [12:0] o;
    o = {link_v_o, link_data_o, chan_o, packet_ready_and_o, error_o};
    if (!link_v_o) o[11:3] = '0;
    return o;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    packet_v_i = '0; link_ready_and_i = 1'b1; reset_n_i = 1'b0;
    @(negedge clk);
    reset_n_i = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] o;
    reset_n_i = 1'b1; packet_v_i = 2'b11; link_ready_and_i = 1'b1; packet_i = '0;
    #1 reset_n_i = 1'b0;
    #2;
    o = {link_v_o, link_data_o, chan_o, packet_ready_and_o, error_o};
    vec_cnt++;
    if ({o[12], o[3:0]} !== 5'b0) begin
      mis_cnt++;
      $display("FAIL reset: got v/chan/ready/err=%b %b %b %b want 0 0 00 0", o[12], o[3], o[2:1], o[0]);
    end
    do_reset();
  endtask

  task automatic test_basic();
    logic [12:0] e[5];
    logic [1:0]  v[5];
    logic [12:0] o;
    packet_i[0 +: PKW] = 23'h6AF365;
    v = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    e = '{ex(0,8'h00,0,2'b01,0), ex(1,8'h65,0,2'b00,0), ex(1,8'hF3,0,2'b00,0),
          ex(1,8'h6A,0,2'b00,0), ex(0,8'h00,0,2'b00,0)};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); packet_v_i = v[i]; link_ready_and_i = 1'b1; #1;
      o = observe();
      vec_cnt++;
      if (o !== e[i]) begin
        mis_cnt++;
        $display("FAIL basic cyc%0d: got %b_%h_%b_%b_%b want %b_%h_%b_%b_%b", i,
                 o[12], o[11:4], o[3], o[2:1], o[0], e[i][12], e[i][11:4], e[i][3], e[i][2:1], e[i][0]);
      end
    end
  endtask

  task automatic test_stall();
    logic [12:0] e[8];
    logic [1:0]  v[8];
    logic        lr[8];
    logic [12:0] o;
    int          vcycles = 0;
    packet_i[0 +: PKW] = 23'h6AF365;
    v  = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    lr = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    e  = '{ex(0,8'h00,0,2'b01,0), ex(1,8'h65,0,2'b00,0), ex(1,8'hF3,0,2'b00,0),
           ex(1,8'hF3,0,2'b00,0), ex(1,8'hF3,0,2'b00,0), ex(1,8'hF3,0,2'b00,0),
           ex(1,8'h6A,0,2'b00,0), ex(0,8'h00,0,2'b00,0)};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); packet_v_i = v[i]; link_ready_and_i = lr[i]; #1;
      o = observe();
      if (link_v_o) vcycles++;
      vec_cnt++;
      if (o !== e[i]) begin
        mis_cnt++;
        $display("FAIL stall cyc%0d: got %b_%h_%b_%b_%b want %b_%h_%b_%b_%b", i,
                 o[12], o[11:4], o[3], o[2:1], o[0], e[i][12], e[i][11:4], e[i][3], e[i][2:1], e[i][0]);
      end
    end
    vec_cnt++;
    if (vcycles !== 6) begin
      mis_cnt++;
      $display("FAIL stall_vcount: got %0d link_v cycles want 6", vcycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] e[10];
    logic [12:0] o;
    do_reset();
    packet_i[0 +: PKW]   = 23'h2A9553;
    packet_i[PKW +: PKW] = 23'h4F03DC;
    e = '{ex(0,8'h00,0,2'b01,0),
          ex(1,8'h53,0,2'b00,0), ex(1,8'h95,0,2'b10,0),
          ex(1,8'hDC,1,2'b00,0), ex(1,8'h03,1,2'b01,0),
          ex(1,8'h53,0,2'b00,0), ex(1,8'h95,0,2'b10,0),
          ex(1,8'hDC,1,2'b00,0), ex(1,8'h03,1,2'b00,0),
          ex(0,8'h00,0,2'b00,0)};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); packet_v_i = (i < 8) ? 2'b11 : 2'b00; link_ready_and_i = 1'b1; #1;
      o = observe();
      vec_cnt++;
      if (o !== e[i]) begin
        mis_cnt++;
        $display("FAIL b2b cyc%0d: got %b_%h_%b_%b_%b want %b_%h_%b_%b_%b", i,
                 o[12], o[11:4], o[3], o[2:1], o[0], e[i][12], e[i][11:4], e[i][3], e[i][2:1], e[i][0]);
      end
    end
  endtask

  task automatic test_len_zero();
    logic [12:0] e[7];
    logic [1:0]  v[7];
    logic [12:0] o;
    do_reset();
    packet_i[0 +: PKW]   = 23'h6AF365;
    packet_i[PKW +: PKW] = 23'h00000A;
    v = '{2'b10, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    e = '{ex(0,8'h00,0,2'b10,0), ex(1,8'h0A,1,2'b00,0), ex(0,8'h00,0,2'b01,0),
          ex(1,8'h65,0,2'b00,0), ex(1,8'hF3,0,2'b00,0), ex(1,8'h6A,0,2'b00,0),
          ex(0,8'h00,0,2'b00,0)};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); packet_v_i = v[i]; link_ready_and_i = 1'b1; #1;
      o = observe();
      vec_cnt++;
      if (o !== e[i]) begin
        mis_cnt++;
        $display("FAIL len0 cyc%0d: got %b_%h_%b_%b_%b want %b_%h_%b_%b_%b", i,
                 o[12], o[11:4], o[3], o[2:1], o[0], e[i][12], e[i][11:4], e[i][3], e[i][2:1], e[i][0]);
      end
    end
  endtask

  task automatic test_oversize();
    logic [12:0] e[9];
    logic [1:0]  v[9];
    logic [12:0] o;
    do_reset();
    packet_i[0 +: PKW] = 23'h568F32;
    v = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    e = '{ex(0,8'h00,0,2'b01,0), ex(1,8'h32,0,2'b00,1), ex(1,8'h8F,0,2'b00,1),
          ex(1,8'h56,0,2'b00,1), ex(0,8'h00,0,2'b01,1), ex(1,8'h65,0,2'b00,1),
          ex(1,8'hF3,0,2'b00,1), ex(1,8'h6A,0,2'b00,1), ex(0,8'h00,0,2'b00,1)};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 4) packet_i[0 +: PKW] = 23'h6AF365;
      packet_v_i = v[i]; link_ready_and_i = 1'b1; #1;
      o = observe();
      vec_cnt++;
      if (o !== e[i]) begin
        mis_cnt++;
        $display("FAIL oversize cyc%0d: got %b_%h_%b_%b_%b want %b_%h_%b_%b_%b", i,
                 o[12], o[11:4], o[3], o[2:1], o[0], e[i][12], e[i][11:4], e[i][3], e[i][2:1], e[i][0]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] e[6];
    logic [12:0] o;
    do_reset();
    packet_i[0 +: PKW] = 23'h6AF365;
    e = '{ex(0,8'h00,0,2'b01,0), ex(1,8'h65,0,2'b00,0), ex(1,8'hF3,0,2'b00,0),
          ex(1,8'h53,0,2'b00,0), ex(1,8'h95,0,2'b00,0), ex(0,8'h00,0,2'b00,0)};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); packet_v_i = (i == 0) ? 2'b01 : 2'b00; link_ready_and_i = 1'b1; #1;
      o = observe();
      vec_cnt++;
      if (o !== e[i]) begin
        mis_cnt++;
        $display("FAIL areset cyc%0d: got %b_%h_%b_%b_%b want %b_%h_%b_%b_%b", i,
                 o[12], o[11:4], o[3], o[2:1], o[0], e[i][12], e[i][11:4], e[i][3], e[i][2:1], e[i][0]);
      end
    end
    // Mid-cycle, well before the next rising edge.
    #2 reset_n_i = 1'b0; packet_v_i = 2'b01;
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin @(negedge clk); #1; end
      else #1;
      vec_cnt++;
      if ({link_v_o, packet_ready_and_o, chan_o, error_o} !== 5'b0) begin
        mis_cnt++;
        $display("FAIL areset_hold%0d: got v/ready/chan/err=%b %b %b %b want 0 00 0 0",
                 k, link_v_o, packet_ready_and_o, chan_o, error_o);
      end
    end
    @(negedge clk);
    reset_n_i = 1'b1;
    packet_i[0 +: PKW] = 23'h2A9553;
    #1;
    o = observe();
    vec_cnt++;
    if (o !== e[0]) begin
      mis_cnt++;
      $display("FAIL areset_release: got %b_%h_%b_%b_%b want %b_%h_%b_%b_%b",
               o[12], o[11:4], o[3], o[2:1], o[0], e[0][12], e[0][11:4], e[0][3], e[0][2:1], e[0][0]);
    end
    for (int i = 3; i < 6; i++) begin
      @(negedge clk); packet_v_i = 2'b00; #1;
      o = observe();
      vec_cnt++;
      if (o !== e[i]) begin
        mis_cnt++;
        $display("FAIL areset_after cyc%0d: got %b_%h_%b_%b_%b want %b_%h_%b_%b_%b", i,
                 o[12], o[11:4], o[3], o[2:1], o[0], e[i][12], e[i][11:4], e[i][3], e[i][2:1], e[i][0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_len_zero();
    test_oversize();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule
